pipe_ifu: RTL and testbench

Instruction-fetch stage of the in-order pipe: owns the architectural fetch PC, issues one instruction-memory request at a time, and registers the returned instruction with its PC into the IF→ID slot consumed by the decode stage. Handles redirect from EX (taken branch/jump/exception) by retargeting the PC, invalidating the IF→ID slot and discarding any in-flight stale response.

---
 rtl/pipe_ifu.sv | 106 ++++++++++
 tb/tb_pipe_ifu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ifu.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight
// and registers the returned instruction with its PC into the IF->ID slot.
package liang_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifToId_t;
endpackage

module pipe_ifu
  import liang_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          redirect_valid_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          imem_req_valid_o,
  input  logic          imem_req_ready_i,
  output logic [31:0]   imem_req_addr_o,
  input  logic          imem_rsp_valid_i,
  input  logic [31:0]   imem_rsp_data_i,
  output logic          if_valid_o,
  input  logic          id_ready_i,
  output ifToId_t       ifToId_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        drop_q;
  logic        out_valid_q;
  ifToId_t     out_q;

  logic        accept;
  logic        rsp;
  logic        rsp_keep;
  logic [31:0] redirect_tgt;

  assign accept       = imem_req_valid_o && imem_req_ready_i;
  assign rsp          = (state_q == WAIT) && imem_rsp_valid_i;
  assign rsp_keep     = rsp && !drop_q && !redirect_valid_i;
  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Redirect never alters the state sequence; it only retargets and flushes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (accept) state_d = WAIT;
      WAIT:    if (imem_rsp_valid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Issue only when the slot is empty or drains this cycle, so a response
  // always finds room without a skid buffer.
  always_comb begin
    imem_req_valid_o = 1'b0;
    if (state_q == REQ) imem_req_valid_o = !out_valid_q || id_ready_i;
  end

  assign imem_req_addr_o = pc_q;
  assign if_valid_o      = out_valid_q;
  assign ifToId_o        = out_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (accept) req_pc_q <= pc_q;

      if (redirect_valid_i)  pc_q <= redirect_tgt;
      else if (accept)       pc_q <= pc_q + 32'd4;

      if (redirect_valid_i) begin
        if (state_q == WAIT)     drop_q <= !imem_rsp_valid_i;
        else if (accept)         drop_q <= 1'b1;
      end else if (rsp) begin
        drop_q <= 1'b0;
      end

      if (redirect_valid_i)              out_valid_q <= 1'b0;
      else if (rsp_keep)                 out_valid_q <= 1'b1;
      else if (out_valid_q && id_ready_i) out_valid_q <= 1'b0;

      if (rsp_keep) begin
        out_q.pc   <= req_pc_q;
        out_q.inst <= imem_rsp_data_i;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ifu.sv
// Randomized bench for pipe_ifu: a toy imem plus a stream model of which PC
// decode must see next.
module tb_pipe_ifu;
  import liang_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        if_valid_o;
  logic        id_ready_i = 1'b0;
  ifToId_t     ifToId_o;

  always #5 clk_i = ~clk_i;

  pipe_ifu #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .if_valid_o(if_valid_o), .id_ready_i(id_ready_i), .ifToId_o(ifToId_o)
  );

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // stimulus knobs
  int unsigned p_rdy, p_idr, p_redir, max_lat;
  bit          force_redir = 0;
  logic [31:0] force_tgt;
  bit          tp_chk = 0, first_req_chk = 0;

  // memory and reference state
  bit          pending = 0;
  int unsigned cnt = 0;
  logic [31:0] mem_addr;
  logic [31:0] exp_pc;
  bit          hold_prev = 0, redir_prev = 0;
  ifToId_t     prev_slot;
  int unsigned n_del = 0, cyc = 0, last_del = 0;

  task automatic step();
    @(posedge clk_i); #1;
    cyc++;
    id_ready_i       = ($urandom_range(99) < p_idr);
    imem_req_ready_i = ($urandom_range(99) < p_rdy);
    redirect_valid_i = force_redir || ($urandom_range(999) < p_redir);
    redirect_pc_i    = force_redir ? force_tgt : $urandom;
    force_redir      = 0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = $urandom;
    if (pending) begin
      if (cnt == 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = inst_of(mem_addr);
        pending = 0;
      end else cnt--;
    end
    @(negedge clk_i);
    if (first_req_chk) begin
      chk("first_req_valid", imem_req_valid_o, 1);
      chk("first_req_addr", imem_req_addr_o, RST_PC);
      first_req_chk = 0;
    end
    if (hold_prev) begin
      chk("hold_valid", if_valid_o, 1);
      chk("hold_slot", ifToId_o, prev_slot);
    end
    if (redir_prev) chk("redirect_flush", if_valid_o, 0);
    hold_prev  = if_valid_o && !id_ready_i && !redirect_valid_i;
    redir_prev = redirect_valid_i;
    prev_slot  = ifToId_o;
    if (if_valid_o && !id_ready_i) chk("req_gate", imem_req_valid_o, 0);
    if (if_valid_o && id_ready_i) begin
      chk("slot_pc", ifToId_o.pc, exp_pc);
      chk("slot_inst", ifToId_o.inst, inst_of(exp_pc));
      if (tp_chk && n_del > 0) chk("throughput", cyc - last_del, 2);
      last_del = cyc;
      n_del++;
      exp_pc += 32'd4;
    end
    if (redirect_valid_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
    if (imem_req_valid_o && imem_req_ready_i) begin
      chk("one_outstanding", pending, 0);
      chk("req_align", imem_req_addr_o[1:0], 0);
      pending  = 1;
      mem_addr = imem_req_addr_o;
      cnt      = $urandom_range(max_lat);
    end
  endtask

  task automatic release_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    redirect_valid_i = 0; imem_rsp_valid_i = 0;
    @(negedge clk_i);
    chk("post_rst_req_valid", imem_req_valid_o, 0);
    chk("post_rst_if_valid", if_valid_o, 0);
    chk("post_rst_slot", ifToId_o, 0);
    exp_pc = RST_PC;
    hold_prev = 0; redir_prev = 0;
    first_req_chk = 1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 30 && !pending; i++) step();
    chk("wait_accept", pending, 1);
  endtask

  initial begin
    int unsigned base;
    #1;
    chk("rst_req_valid", imem_req_valid_o, 0);
    chk("rst_if_valid", if_valid_o, 0);
    chk("rst_slot", ifToId_o, 0);
    repeat (2) @(posedge clk_i);

    // zero-wait memory, always-ready decode: one instruction every 2 cycles
    p_rdy = 100; p_idr = 100; p_redir = 0; max_lat = 0; tp_chk = 1;
    release_reset();
    repeat (14) step();
    chk("tp_count", n_del >= 5, 1);
    tp_chk = 0;

    // decode stall with a full slot, then release
    p_idr = 0;
    repeat (10) step();
    chk("stall_slot_full", if_valid_o, 1);
    p_idr = 100;
    step();
    chk("unstall_req", pending, 1);
    chk("unstall_req_addr", mem_addr, exp_pc);

    // slow response, redirect in second WAIT cycle to an unaligned target
    repeat (4) step();
    max_lat = 4; p_rdy = 100;
    wait_accept();
    max_lat = 0;
    step();
    force_redir = 1; force_tgt = 32'h8000_0103;
    step();
    base = n_del;
    for (int i = 0; i < 20 && n_del == base; i++) step();
    chk("redir_delivered", n_del > base, 1);
    chk("redir_next_pc", exp_pc, 32'h8000_0104);

    // PC wrap
    force_redir = 1; force_tgt = 32'hFFFF_FFFC;
    step();
    base = n_del;
    repeat (10) step();
    chk("wrap_count", n_del >= base + 3, 1);

    // random traffic
    p_rdy = 70; p_idr = 70; p_redir = 50; max_lat = 3;
    repeat (3000) step();
    chk("random_delivered", n_del > 300, 1);

    // asynchronous reset while a request is outstanding
    p_redir = 0; max_lat = 5;
    wait_accept();
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_req_valid", imem_req_valid_o, 0);
    chk("async_rst_if_valid", if_valid_o, 0);
    chk("async_rst_slot", ifToId_o, 0);
    pending = 0;
    repeat (2) @(posedge clk_i);
    p_rdy = 100; p_idr = 100; max_lat = 1;
    release_reset();
    base = n_del;
    repeat (12) step();
    chk("restart_count", n_del >= base + 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
